// File: rtl/dmi_pkg.sv
// ============================================================================
//  Module   : dmi_pkg
//  Purpose  : Shared state encoding and DMI op-status codes for dmi_req_ctrl.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package dmi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2
    } dmi_req_state_e;

    localparam logic [1:0] DMI_OP_OK     = 2'd0;
    localparam logic [1:0] DMI_OP_FAILED = 2'd2;
    localparam logic [1:0] DMI_OP_BUSY   = 2'd3;

endpackage

`default_nettype wire

// File: rtl/dmi_pulse_sync.sv
// ============================================================================
//  Module   : dmi_pulse_sync
//  Purpose  : Multi-flop synchronizer with rising-edge detect for TAP strobes.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module dmi_pulse_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_l,
    input  logic i_async,
    output logic o_level,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/dmi_req_ctrl.sv
// ============================================================================
//  Module   : dmi_req_ctrl
//  Purpose  : Turns synchronized TAP DMI strobes into one valid/ready request,
//             tracks the response and the sticky dmistat for DR capture.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module dmi_req_ctrl
    import dmi_pkg::*;
#(
    parameter int ABITS       = 7,
    parameter int SYNC_STAGES = 2,
    parameter int RSP_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             tap_req_intf,
    input  logic             tap_req_en,
    input  logic [31:0]      tap_addr,
    input  logic [31:0]      tap_wdata,
    input  logic             tap_dmi_reset,
    input  logic             tap_dmi_hard_reset,
    output logic [31:0]      tap_rd_data,
    output logic [1:0]       tap_rd_status,
    output logic [1:0]       tap_dmi_stat,
    output logic             dmi_req_valid,
    input  logic             dmi_req_ready,
    output logic [ABITS-1:0] dmi_req_addr,
    output logic [31:0]      dmi_req_wdata,
    output logic             dmi_req_we,
    input  logic             dmi_rsp_valid,
    input  logic [31:0]      dmi_rsp_rdata,
    input  logic             dmi_rsp_err
);

    localparam int                 c_cnt_w   = (RSP_TIMEOUT > 0) ? $clog2(RSP_TIMEOUT + 1) : 1;
    localparam int                 c_to_last = (RSP_TIMEOUT > 0) ? RSP_TIMEOUT - 1 : 0;
    localparam logic [c_cnt_w-1:0] c_to_cmp  = c_cnt_w'(c_to_last);

    dmi_req_state_e     r_state;
    dmi_req_state_e     w_state_next;
    logic [1:0]         r_stat;
    logic [1:0]         w_stat_next;
    logic [ABITS-1:0]   r_addr;
    logic [31:0]        r_wdata;
    logic               r_we;
    logic [31:0]        r_rd_data;
    logic [c_cnt_w-1:0] r_cnt;

    logic w_req_pulse, w_req_level, w_we_s, w_we_rise;
    logic w_rst_pulse, w_rst_level, w_hrst_pulse, w_hrst_level;
    logic w_accept, w_rsp_done, w_busy, w_timeout;

    dmi_pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_req (
        .clk(clk), .rst_l(rst_l), .i_async(tap_req_intf),
        .o_level(w_req_level), .o_rise(w_req_pulse));

    dmi_pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_we (
        .clk(clk), .rst_l(rst_l), .i_async(tap_req_en),
        .o_level(w_we_s), .o_rise(w_we_rise));

    dmi_pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rst (
        .clk(clk), .rst_l(rst_l), .i_async(tap_dmi_reset),
        .o_level(w_rst_level), .o_rise(w_rst_pulse));

    dmi_pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_hrst (
        .clk(clk), .rst_l(rst_l), .i_async(tap_dmi_hard_reset),
        .o_level(w_hrst_level), .o_rise(w_hrst_pulse));

    logic w_unused;
    assign w_unused = ^{w_req_level, w_we_rise, w_rst_level, w_hrst_level, tap_addr};

    // Timeout fires on the edge at which the WAIT_RSP cycle count reaches RSP_TIMEOUT.
    assign w_timeout = (RSP_TIMEOUT != 0) && (r_state == ST_WAIT_RSP) && (r_cnt == c_to_cmp);
    assign w_busy    = w_req_pulse && (r_state != ST_IDLE);

    always_comb begin
        w_state_next = r_state;
        w_stat_next  = r_stat;
        w_accept     = 1'b0;
        w_rsp_done   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_req_pulse && (r_stat == DMI_OP_OK)) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (dmi_req_ready) begin
                    w_state_next = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (dmi_rsp_valid) begin
                    w_rsp_done   = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_timeout) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        if (r_stat == DMI_OP_OK) begin
            if (w_busy) begin
                w_stat_next = DMI_OP_BUSY;
            end else if ((w_rsp_done && dmi_rsp_err) || (w_timeout && !dmi_rsp_valid)) begin
                w_stat_next = DMI_OP_FAILED;
            end
        end
        if (w_rst_pulse) begin
            w_stat_next = DMI_OP_OK;
        end

        if (w_hrst_pulse) begin
            w_state_next = ST_IDLE;
            w_stat_next  = DMI_OP_OK;
            w_accept     = 1'b0;
            w_rsp_done   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_stat    <= DMI_OP_OK;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_we      <= 1'b0;
            r_rd_data <= '0;
            r_cnt     <= '0;
        end else begin
            r_stat <= w_stat_next;
            if (w_accept) begin
                r_addr  <= tap_addr[ABITS-1:0];
                r_wdata <= tap_wdata;
                r_we    <= w_we_s;
            end
            if (w_rsp_done && !r_we) begin
                r_rd_data <= dmi_rsp_rdata;
            end
            if (r_state != ST_WAIT_RSP) begin
                r_cnt <= '0;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign dmi_req_valid = (r_state == ST_REQ);
    assign dmi_req_addr  = r_addr;
    assign dmi_req_wdata = r_wdata;
    assign dmi_req_we    = r_we;
    assign tap_rd_data   = r_rd_data;
    assign tap_dmi_stat  = r_stat;
    assign tap_rd_status = (r_state != ST_IDLE) ? DMI_OP_BUSY : r_stat;

endmodule

`default_nettype wire
